canvas_access_sched: RTL

Scheduler and owner of the 32×32 one-bit drawing canvas that feeds the digit classifier. It serialises three requesters onto the canvas storage, all in the clkVga domain:
- mouse-driven paint stamps;
- a full-canvas clear;
- a consistent snapshot for the DNN.

It also serves a registered single-pixel read port for the VGA raster.

---
 rtl/canvas_access_sched_if.sv | 29 ++
 rtl/canvas_access_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/canvas_access_sched_if.sv
// Request/response bundle between the canvas requesters (paint, clear,
// snapshot, VGA read) and canvas_access_sched.
interface canvas_access_sched_if;
  localparam int unsigned COORD_W = 5;
  localparam int unsigned PIX_N   = 1 << (2 * COORD_W);

  logic               iPaintReq;
  logic [COORD_W-1:0] iPaintCol;
  logic [COORD_W-1:0] iPaintRow;
  logic               oPaintAck;
  logic               iClearReq;
  logic               iSnapReq;
  logic               oSnapValid;
  logic [PIX_N-1:0]   oSnapshot;
  logic [COORD_W-1:0] iRdCol;
  logic [COORD_W-1:0] iRdRow;
  logic               oRdPix;
  logic               oBusy;

  modport master (
    output iPaintReq, iPaintCol, iPaintRow, iClearReq, iSnapReq, iRdCol, iRdRow,
    input  oPaintAck, oSnapValid, oSnapshot, oRdPix, oBusy
  );

  modport slave (
    input  iPaintReq, iPaintCol, iPaintRow, iClearReq, iSnapReq, iRdCol, iRdRow,
    output oPaintAck, oSnapValid, oSnapshot, oRdPix, oBusy
  );
endinterface

// File: rtl/canvas_access_sched.sv
// canvas_access_sched: owns the 32x32 one-bit drawing canvas and serialises
// paint stamps, full clears and DNN snapshots onto it, plus a registered
// single-pixel read port for the VGA raster.
// Canvas bit index is {col,row} = col*32 + row.
// Build option: define CANVAS_WIDE_BRUSH_EN for the 5-cell plus-shaped brush;
// otherwise a single-cell brush (centre write followed by one commit cycle).
module canvas_access_sched #(
  parameter int unsigned STAMP_CELLS = 5,
  parameter int unsigned CLEAR_COLS  = 32
) (
  input  logic                 clkVga,
  input  logic                 iRstN,
  canvas_access_sched_if.slave bus
);

  localparam int unsigned COORD_W = 5;
  localparam int unsigned IDX_W   = 2 * COORD_W;
  localparam int unsigned PIX_N   = 1 << IDX_W;
  localparam int unsigned ROWS    = 1 << COORD_W;
  // Step counter is sized for the widest brush in either build.
  localparam int unsigned STEP_W  = (STAMP_CELLS > 2) ? $clog2(STAMP_CELLS) : 1;
`ifdef CANVAS_WIDE_BRUSH_EN
  localparam int unsigned      STAMP_LAST = STAMP_CELLS - 1;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;
`else
  localparam int unsigned      STAMP_LAST = 1;
`endif

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR, SNAP} state_t;

  state_t             state, state_nxt;
  logic [PIX_N-1:0]   canvas;
  logic [COORD_W-1:0] stamp_col, stamp_row;
  logic [COORD_W-1:0] clr_col;
  logic [STEP_W-1:0]  step;
  logic               clr_pend, snap_pend;

  logic               grant_stamp, grant_clear, grant_snap;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               clr_en;
  logic               stamp_done;
  logic               snap_copy;

  // State register.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration, stamp cell selection and per-state control.
  always_comb begin
    state_nxt   = state;
    grant_stamp = 1'b0;
    grant_clear = 1'b0;
    grant_snap  = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    clr_en      = 1'b0;
    stamp_done  = 1'b0;
    snap_copy   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_pend) begin
          grant_clear = 1'b1;
          state_nxt   = CLEAR;
        end else if (snap_pend) begin
          grant_snap  = 1'b1;
          state_nxt   = SNAP;
        end else if (bus.iPaintReq && !bus.oPaintAck) begin
          // Ack cycle still sees the old request level; ignore it.
          grant_stamp = 1'b1;
          state_nxt   = STAMP;
        end
      end
      STAMP: begin
        if (step == STEP_W'(0)) begin
          wr_en  = 1'b1;
          wr_idx = {stamp_col, stamp_row};
        end
`ifdef CANVAS_WIDE_BRUSH_EN
        // Off-canvas neighbours are skipped but still take their cycle.
        else if (step == STEP_W'(1)) begin
          wr_en  = (stamp_row != '0);
          wr_idx = {stamp_col, stamp_row - COORD_W'(1)};
        end else if (step == STEP_W'(2)) begin
          wr_en  = (stamp_row != COORD_MAX);
          wr_idx = {stamp_col, stamp_row + COORD_W'(1)};
        end else if (step == STEP_W'(3)) begin
          wr_en  = (stamp_col != '0);
          wr_idx = {stamp_col - COORD_W'(1), stamp_row};
        end else if (step == STEP_W'(4)) begin
          wr_en  = (stamp_col != COORD_MAX);
          wr_idx = {stamp_col + COORD_W'(1), stamp_row};
        end
`endif
        if (step == STEP_W'(STAMP_LAST)) begin
          stamp_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (clr_col == COORD_W'(CLEAR_COLS - 1)) state_nxt = IDLE;
      end
      SNAP: begin
        snap_copy = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending flags; a pulse while already pending merges into one service.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      clr_pend  <= 1'b0;
      snap_pend <= 1'b0;
    end else begin
      clr_pend  <= grant_clear ? 1'b0 : (clr_pend  | bus.iClearReq);
      snap_pend <= grant_snap  ? 1'b0 : (snap_pend | bus.iSnapReq);
    end
  end

  // Stamp centre latch and step counter.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      stamp_col <= '0;
      stamp_row <= '0;
      step      <= '0;
    end else if (grant_stamp) begin
      stamp_col <= bus.iPaintCol;
      stamp_row <= bus.iPaintRow;
      step      <= '0;
    end else if (state == STAMP) begin
      step      <= step + STEP_W'(1);
    end
  end

  // Clear column counter.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN)           clr_col <= '0;
    else if (grant_clear) clr_col <= '0;
    else if (clr_en)      clr_col <= clr_col + COORD_W'(1);
  end

  // Canvas storage: stamp writes set bits, clear zeroes one column per cycle.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      canvas <= '0;
    end else begin
      if (wr_en) canvas[wr_idx] <= 1'b1;
      if (clr_en) begin
        for (int r = 0; r < ROWS; r++) canvas[{clr_col, COORD_W'(r)}] <= 1'b0;
      end
    end
  end

  // Registered outputs: handshake pulses, snapshot, VGA pixel, busy.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      bus.oPaintAck  <= 1'b0;
      bus.oSnapValid <= 1'b0;
      bus.oSnapshot  <= '0;
      bus.oRdPix     <= 1'b0;
      bus.oBusy      <= 1'b0;
    end else begin
      bus.oPaintAck  <= stamp_done;
      bus.oSnapValid <= snap_copy;
      if (snap_copy) bus.oSnapshot <= canvas;
      bus.oRdPix     <= canvas[{bus.iRdCol, bus.iRdRow}];
      bus.oBusy      <= (state_nxt != IDLE);
    end
  end

endmodule
